// File: rtl/fetch_pkg.sv
// Shared types and constants for the mini-rv instruction fetch path.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    OUT  = 2'd2
  } fetch_state_t;

  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage

// File: rtl/fetch_controller.sv
// Fetch sequencer: one outstanding imem request, a one-entry decode buffer,
// and squashing of in-flight fetches when execute redirects the PC.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_stall,
  output logic              pc_branch_taken,
  output logic [ADDR_W-1:0] pc_branch_target,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              misaligned_err,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_resp_valid,
  input  logic [DATA_W-1:0] imem_resp_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc
);

  fetch_state_t      state;
  logic              kill;
  logic [ADDR_W-1:0] req_pc;

  // Valids gate on redirect only, so no ready-to-valid combinational loop forms.
  assign imem_req_valid   = (state == REQ) && !redirect_valid;
  assign imem_addr        = pc;
  assign instr_valid      = (state == OUT) && !redirect_valid;
  assign pc_branch_taken  = redirect_valid;
  assign pc_branch_target = {redirect_target[ADDR_W-1:2], 2'b00};
  assign pc_stall         = !(redirect_valid || (imem_req_valid && imem_req_ready));

  // Fetch FSM, kill flag, decode buffer and misalignment pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= REQ;
      kill           <= 1'b0;
      req_pc         <= '0;
      instr          <= '0;
      instr_pc       <= '0;
      misaligned_err <= 1'b0;
    end else begin
      misaligned_err <= redirect_valid && (redirect_target[1:0] != 2'b00);
      case (state)
        REQ: begin
          if (imem_req_valid && imem_req_ready) begin
            req_pc <= pc;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (imem_resp_valid) begin
            // A redirect coinciding with the response squashes it just like a stale kill.
            kill <= 1'b0;
            if (kill || redirect_valid) begin
              state <= REQ;
            end else begin
              instr    <= imem_resp_data;
              instr_pc <= req_pc;
              state    <= OUT;
            end
          end else if (redirect_valid) begin
            kill <= 1'b1;
          end
        end
        OUT: begin
          if (redirect_valid) begin
            state <= REQ;
          end else if (instr_valid && instr_ready) begin
            state <= REQ;
          end
        end
        default: begin
          state <= REQ;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequences instruction fetch for the mini-rv core. It drives the program counter's `stall`, `branch_taken` and `branch_target` inputs, issues one instruction-memory request at a time with a valid/ready handshake, and buffers the returned word for decode. It squashes any in-flight fetch when execute signals a redirect. It sits between `program_counter`, the instruction memory port and the decode stage.

## Interface
Parameters:
- `ADDR_W`, 32, address width; must equal the PC width.
- `DATA_W`, 32, instruction word width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset: synchronous, active-high.
- `pc`  in  ADDR_W  current value from `program_counter`.
- `pc_stall`  out  1  to `program_counter.stall`.
- `pc_branch_taken`  out  1  to `program_counter.branch_taken`.
- `pc_branch_target`  out  ADDR_W  to `program_counter.branch_target`.
- `redirect_valid`  in  1  execute requests a PC redirect this cycle.
- `redirect_target`  in  ADDR_W  redirect address.
- `misaligned_err`  out  1  one-cycle pulse: redirect target had bits [1:0] ≠ 0.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_addr`  out  ADDR_W  fetch address.
- `imem_resp_valid`  in  1  response word valid; exactly one per accepted request.
- `imem_resp_data`  in  DATA_W  response word.
- `instr_valid`  out  1  buffered instruction valid to decode.
- `instr_ready`  in  1  decode accepts the instruction.
- `instr`  out  DATA_W  buffered instruction.
- `instr_pc`  out  ADDR_W  address of `instr`.

## Operation
- States: `REQ`, `WAIT`, `OUT`. At most one memory request is outstanding.
- **REQ**
  - `imem_req_valid = !redirect_valid`; `imem_addr = pc`.
  - On handshake: capture `pc` into `req_pc`, go to `WAIT`. The PC advances in the same cycle.
- **WAIT**
  - Response with `kill = 0`: capture the word into `instr` and `req_pc` into `instr_pc`, go to `OUT`.
  - Response with `kill = 1`: drop the word, clear `kill`, go to `REQ`.
- **OUT**
  - `instr_valid = !redirect_valid`.
  - On `instr_valid && instr_ready`: go to `REQ`.
- **Redirect handling** (any state, highest priority):
  - `pc_branch_taken = redirect_valid`.
  - `pc_branch_target = {redirect_target[ADDR_W-1:2], 2'b00}`.
  - `misaligned_err = redirect_valid && |redirect_target[1:0]`.
  - In `WAIT`: set `kill` (or keep it set) and stay in `WAIT`.
  - In `OUT`: discard the buffer, go to `REQ`.
  - In `REQ`: no request is issued that cycle.
- **PC stall:** `pc_stall = !(redirect_valid || (imem_req_valid && imem_req_ready))`. The PC moves only on redirect or accepted request.
- **Simultaneous events:**
  - Redirect and response in the same `WAIT` cycle: drop the response, clear `kill`, go to `REQ`. The PC loads the target.
  - Repeated redirects while in `WAIT`: `kill` remains a single flag. Only one response is pending.
  - A response arriving in `REQ` or `OUT` is a protocol violation. It is ignored and covered by a bench assertion.

## Timing
- **Reset values:** state `REQ`, `kill = 0`, `instr = 0`, `instr_pc = 0`, `instr_valid = 0`, `misaligned_err = 0`.
- **After reset:** the request to address 0 is visible in the first cycle after reset deasserts.
- **Reset mid-operation:** state returns to `REQ` and `kill` clears. The memory is reset by the same signal, so no stale response follows.
- **Latency:** response in cycle N gives `instr_valid` in cycle N+1.
- **Throughput:** best case one instruction per 3 cycles (REQ handshake, 1-cycle memory, OUT accepted).
- **Combinational paths:**
  - `imem_req_valid` and `instr_valid` depend combinationally on `redirect_valid` only, never on a ready input.
  - `pc_*` outputs are combinational.
- **Address arithmetic:** the `+4` increment lives in `program_counter`. Wrap from 0xFFFF_FFFC to 0 is legal and unflagged.

## Structure
- `fetch_pkg` holds:
  - `fetch_state_t` enum (`REQ`, `WAIT`, `OUT`);
  - `INSTR_BYTES = 4`;
  - `NOP_INSTR = 32'h0000_0013`, which the bench uses as filler.
- No sub-module. The parent instantiates `fetch_controller` next to `program_counter`.

## Test plan
- **Reset then 1-cycle memory, decode always ready:** requests go to 0x0, 0x4, 0x8, each 3 cycles apart. `instr_pc` matches, and `pc` reads 0x4 the cycle after the first handshake.
- **`imem_req_ready` low for 4 cycles in `REQ`:** `pc_stall` = 1 throughout, `pc` holds 0x0, and `imem_addr` stays stable.
- **Redirect to 0x100 in `WAIT`, response 3 cycles later with 0xDEADBEEF:** the word is dropped, `instr_valid` never rises, and the next request is to 0x100.
- **Redirect to 0x202 while `OUT` holds an instruction:** `instr_valid` drops that cycle, `misaligned_err` pulses once, and the next request is to 0x200.
- **`instr_ready` low for 5 cycles in `OUT`:**
  - `instr` and `instr_pc` stay stable;
  - no new `imem_req_valid`;
  - `pc_stall` = 1.
- **Reset asserted in `WAIT`:** the cycle after reset, `imem_req_valid` = 1 with address 0x0, and `kill` = 0.
